// File: rtl/alu_muldiv.sv
`default_nettype none
//==============================================================================
// Module   : alu_muldiv
// Brief    : Iterative shift-add multiply / restoring divide (MULU, MUL, DIVU,
//            DIV) for byte and word operands. Optional macro
//            MULDIV_EARLY_OUT_EN ends a multiply once no multiplier bits remain.
// Revision : 1.0
//==============================================================================
module alu_muldiv #(
    parameter int DATA_W         = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              wide,
    input  logic [DATA_W-1:0] a_hi,
    input  logic [DATA_W-1:0] a_lo,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result_lo,
    output logic [DATA_W-1:0] result_hi,
    output logic              cy_v,
    output logic              div_error,
    output logic [5:0]        cycles
);

    localparam int c_HALF_W = DATA_W / 2;
    localparam int c_PROD_W = 2 * DATA_W;

    localparam logic [5:0] c_ITERS_WORD = 6'(DATA_W / BITS_PER_CYCLE);
    localparam logic [5:0] c_ITERS_BYTE = 6'(c_HALF_W / BITS_PER_CYCLE);

    localparam logic [DATA_W-1:0] c_LIM_WORD = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] c_LIM_BYTE = {{c_HALF_W{1'b0}}, 1'b1, {(c_HALF_W-1){1'b0}}};

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_ITER = 2'd2;
    localparam logic [1:0] c_ST_FIX  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_accept;
    logic                w_load;
    logic                w_iter;
    logic                w_fix;

    logic [1:0]          r_op;
    logic                r_wide;
    logic [DATA_W-1:0]   r_a_hi;
    logic [DATA_W-1:0]   r_a_lo;
    logic [DATA_W-1:0]   r_b;

    logic [c_PROD_W-1:0] r_acc;
    logic [c_PROD_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_dvs;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_dz;
    logic                r_ovf;
    logic [5:0]          r_cnt;

    logic                r_done;
    logic [DATA_W-1:0]   r_res_lo;
    logic [DATA_W-1:0]   r_res_hi;
    logic                r_cy_v;
    logic                r_div_err;
    logic [5:0]          r_cycles;

    logic                w_is_div;
    logic                w_is_signed;
    logic [DATA_W-1:0]   w_mc_ext;
    logic [DATA_W-1:0]   w_mp_ext;
    logic                w_mc_neg;
    logic                w_mp_neg;
    logic [DATA_W-1:0]   w_mc_mag;
    logic [DATA_W-1:0]   w_mp_mag;
    logic [c_PROD_W-1:0] w_dvd_ext;
    logic [c_PROD_W-1:0] w_dvd_mag;
    logic                w_dvd_neg;
    logic [DATA_W-1:0]   w_dvd_top;
    logic [DATA_W-1:0]   w_dvd_low;
    logic                w_dz;

    logic [c_PROD_W-1:0] w_acc_nxt;
    logic [c_PROD_W-1:0] w_mcand_nxt;
    logic [DATA_W-1:0]   w_mplier_nxt;
    logic [DATA_W-1:0]   w_rem_nxt;
    logic [DATA_W-1:0]   w_quo_nxt;
    logic [DATA_W:0]     w_trial;
    logic [DATA_W:0]     w_diff;
    logic [5:0]          w_iter_target;
    logic                w_early;
    logic                w_iter_last;

    logic [c_PROD_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_q;
    logic [DATA_W-1:0]   w_r;
    logic [DATA_W-1:0]   w_q_lim;
    logic                w_q_big;
    logic                w_div_err;
    logic                w_mul_ovf;

    assign w_is_div    = r_op[1];
    assign w_is_signed = r_op[0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = c_ST_LOAD;
            // Zero divisor skips ITER; FIX reports the fault one edge later.
            c_ST_LOAD: w_state_nxt = w_dz ? c_ST_FIX : c_ST_ITER;
            c_ST_ITER: if (w_iter_last) w_state_nxt = c_ST_FIX;
            c_ST_FIX:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (r_state != c_ST_IDLE);
        w_accept = (r_state == c_ST_IDLE) & start;
        w_load   = (r_state == c_ST_LOAD);
        w_iter   = (r_state == c_ST_ITER);
        w_fix    = (r_state == c_ST_FIX);
    end

    // Operand magnitudes and signs from the latched request.
    always_comb begin
        w_mc_ext  = r_wide ? r_a_lo
                  : {{c_HALF_W{w_is_signed & r_a_lo[c_HALF_W-1]}}, r_a_lo[c_HALF_W-1:0]};
        w_mp_ext  = r_wide ? r_b
                  : {{c_HALF_W{w_is_signed & r_b[c_HALF_W-1]}}, r_b[c_HALF_W-1:0]};
        w_mc_neg  = w_is_signed & w_mc_ext[DATA_W-1];
        w_mp_neg  = w_is_signed & w_mp_ext[DATA_W-1];
        w_mc_mag  = w_mc_neg ? -w_mc_ext : w_mc_ext;
        w_mp_mag  = w_mp_neg ? -w_mp_ext : w_mp_ext;
        w_dvd_ext = r_wide ? {r_a_hi, r_a_lo}
                  : {{DATA_W{w_is_signed & r_a_lo[DATA_W-1]}}, r_a_lo};
        w_dvd_neg = w_is_signed & w_dvd_ext[c_PROD_W-1];
        w_dvd_mag = w_dvd_neg ? -w_dvd_ext : w_dvd_ext;
        // Byte dividend is left-aligned so the next bit to shift is always the MSB.
        w_dvd_top = r_wide ? w_dvd_mag[c_PROD_W-1:DATA_W]
                  : {{c_HALF_W{1'b0}}, w_dvd_mag[DATA_W-1:c_HALF_W]};
        w_dvd_low = r_wide ? w_dvd_mag[DATA_W-1:0]
                  : {w_dvd_mag[c_HALF_W-1:0], {c_HALF_W{1'b0}}};
        w_dz      = w_is_div & (w_mp_mag == '0);
    end

    // One iteration: BITS_PER_CYCLE shift-add and restoring-divide steps.
    always_comb begin
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_rem_nxt    = r_rem;
        w_quo_nxt    = r_quo;
        w_trial      = '0;
        w_diff       = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (w_mplier_nxt[0]) w_acc_nxt = w_acc_nxt + w_mcand_nxt;
            w_mcand_nxt  = w_mcand_nxt << 1;
            w_mplier_nxt = w_mplier_nxt >> 1;
            w_trial      = {w_rem_nxt, w_quo_nxt[DATA_W-1]};
            w_diff       = w_trial - {1'b0, r_dvs};
            w_rem_nxt    = w_diff[DATA_W] ? w_trial[DATA_W-1:0] : w_diff[DATA_W-1:0];
            w_quo_nxt    = {w_quo_nxt[DATA_W-2:0], ~w_diff[DATA_W]};
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = ~w_is_div & (w_mplier_nxt == '0);
`else
    assign w_early = 1'b0;
`endif

    assign w_iter_target = r_wide ? c_ITERS_WORD : c_ITERS_BYTE;
    assign w_iter_last   = (r_cnt + 6'd1 == w_iter_target) | w_early;

    // Sign fix-up, overflow and range checks.
    always_comb begin
        w_prod    = r_neg_q ? -r_acc : r_acc;
        w_q       = r_neg_q ? -r_quo : r_quo;
        w_r       = r_neg_r ? -r_rem : r_rem;
        w_q_lim   = r_wide ? c_LIM_WORD : c_LIM_BYTE;
        w_q_big   = r_neg_q ? (r_quo > w_q_lim) : (r_quo >= w_q_lim);
        w_div_err = r_dz | r_ovf | (w_is_signed & w_q_big);
        if (r_wide) begin
            w_mul_ovf = w_is_signed
                      ? (w_prod[c_PROD_W-1:DATA_W] != {DATA_W{w_prod[DATA_W-1]}})
                      : (w_prod[c_PROD_W-1:DATA_W] != '0);
        end else begin
            w_mul_ovf = w_is_signed
                      ? (w_prod[DATA_W-1:c_HALF_W] != {c_HALF_W{w_prod[c_HALF_W-1]}})
                      : (w_prod[DATA_W-1:c_HALF_W] != '0);
        end
    end

    // Datapath registers; only meaningful while busy, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= op;
            r_wide <= wide;
            r_a_hi <= a_hi;
            r_a_lo <= a_lo;
            r_b    <= b;
        end
        if (w_load) begin
            r_acc    <= '0;
            r_mcand  <= {{DATA_W{1'b0}}, w_mc_mag};
            r_mplier <= w_mp_mag;
            r_rem    <= w_dvd_top;
            r_quo    <= w_dvd_low;
            r_dvs    <= w_mp_mag;
            r_neg_q  <= w_is_div ? (w_dvd_neg ^ w_mp_neg) : (w_mc_neg ^ w_mp_neg);
            r_neg_r  <= w_dvd_neg;
            r_dz     <= w_dz;
            r_ovf    <= w_is_div & (w_dvd_top >= w_mp_mag);
            r_cnt    <= '0;
        end
        if (w_iter) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_cnt    <= r_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done    <= 1'b0;
            r_res_lo  <= '0;
            r_res_hi  <= '0;
            r_cy_v    <= 1'b0;
            r_div_err <= 1'b0;
            r_cycles  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_fix) begin
                r_done   <= 1'b1;
                r_cycles <= r_cnt;
                if (w_is_div) begin
                    r_div_err <= w_div_err;
                    if (!w_div_err) begin
                        r_res_lo <= r_wide ? w_q : {{c_HALF_W{1'b0}}, w_q[c_HALF_W-1:0]};
                        r_res_hi <= r_wide ? w_r : {{c_HALF_W{1'b0}}, w_r[c_HALF_W-1:0]};
                    end
                end else begin
                    r_div_err <= 1'b0;
                    r_cy_v    <= w_mul_ovf;
                    r_res_lo  <= w_prod[DATA_W-1:0];
                    r_res_hi  <= r_wide ? w_prod[c_PROD_W-1:DATA_W] : '0;
                end
            end
        end
    end

    assign done      = r_done;
    assign result_lo = r_res_lo;
    assign result_hi = r_res_hi;
    assign cy_v      = r_cy_v;
    assign div_error = r_div_err;
    assign cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
//==============================================================================
// Module   : tb_alu_muldiv
// Brief    : Scoreboard bench for alu_muldiv: directed vectors push expected
//            responses, a done-triggered monitor pops and compares them.
// Revision : 1.0
//==============================================================================
module tb_alu_muldiv;

    localparam int c_W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     op;
    logic           wide;
    logic [c_W-1:0] a_hi;
    logic [c_W-1:0] a_lo;
    logic [c_W-1:0] b;
    logic           busy;
    logic           done;
    logic [c_W-1:0] result_lo;
    logic [c_W-1:0] result_hi;
    logic           cy_v;
    logic           div_error;
    logic [5:0]     cycles;

    alu_muldiv #(.DATA_W(c_W), .BITS_PER_CYCLE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .wide      (wide),
        .a_hi      (a_hi),
        .a_lo      (a_lo),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .cy_v      (cy_v),
        .div_error (div_error),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             id;
        logic [c_W-1:0] lo;
        logic [c_W-1:0] hi;
        logic           cy;
        logic           err;
        int             ncyc;
        int             lat;
        int             s;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [c_W-1:0] last_lo = '0;
    logic [c_W-1:0] last_hi = '0;
    logic           last_cy = 1'b0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", nm, id, act, exp);
        end
    endtask

    function automatic int mcyc(input int full, input int early);
`ifdef MULDIV_EARLY_OUT_EN
        return early;
`else
        return full;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1, expected no pending request");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_lo", e.id, result_lo, e.lo);
                chk("result_hi", e.id, result_hi, e.hi);
                chk("cy_v",      e.id, cy_v,      e.cy);
                chk("div_error", e.id, div_error, e.err);
                chk("cycles",    e.id, cycles,    e.ncyc);
                chk("latency",   e.id, cyc - e.s - 1, e.lat);
                chk("busy_at_done", e.id, busy, 0);
            end
        end
    end

    // Issue one request at a negedge and wait for its done; errors and divides
    // keep the previously reported values where the block holds them.
    task automatic issue(input int id, input logic [1:0] o, input logic w,
                         input logic [c_W-1:0] ah, input logic [c_W-1:0] al,
                         input logic [c_W-1:0] bb, input logic [c_W-1:0] elo,
                         input logic [c_W-1:0] ehi, input logic ecy, input logic eerr,
                         input int ncyc, input logic poke);
        exp_t e;
        op = o; wide = w; a_hi = ah; a_lo = al; b = bb; start = 1'b1;
        e.id   = id;
        e.err  = eerr;
        e.lo   = eerr ? last_lo : elo;
        e.hi   = eerr ? last_hi : ehi;
        e.cy   = o[1] ? last_cy : ecy;
        e.ncyc = ncyc;
        e.lat  = ncyc + 2;
        e.s    = cyc;
        last_lo = e.lo;
        last_hi = e.hi;
        last_cy = e.cy;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", id, busy, 1);
        for (int i = 0; i < 100 && !done; i++) begin
            start = poke && (i == 3);
            if (poke && i == 3) begin
                op = 2'd0; wide = 1'b1; a_lo = 16'hAAAA; b = 16'h5555;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout (vec %0d): got no done, expected done within 100 cycles", id);
            sb.delete();
        end
    endtask

    task automatic chk_zero(input int id);
        chk("rst_busy",      id, busy,      0);
        chk("rst_done",      id, done,      0);
        chk("rst_result_lo", id, result_lo, 0);
        chk("rst_result_hi", id, result_hi, 0);
        chk("rst_cy_v",      id, cy_v,      0);
        chk("rst_div_error", id, div_error, 0);
        chk("rst_cycles",    id, cycles,    0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; wide = 1'b0;
        a_hi = '0; a_lo = '0; b = '0;
        repeat (3) @(negedge clk);
        chk_zero(0);
        reset = 1'b0;
        @(negedge clk);

        //     id op    w     a_hi      a_lo      b         lo        hi        cy    err   cycles         poke
        issue( 1, 2'd0, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, mcyc(16, 16), 1'b0);
        issue( 2, 2'd1, 1'b0, 16'h0000, 16'h00FD, 16'h0005, 16'hFFF1, 16'h0000, 1'b0, 1'b0, mcyc(8, 3),   1'b0);
        issue( 3, 2'd2, 1'b1, 16'h0001, 16'h0000, 16'h0003, 16'h5555, 16'h0001, 1'b0, 1'b0, 16,           1'b1);
        issue( 4, 2'd3, 1'b0, 16'h0000, 16'hFFF9, 16'h0002, 16'h00FD, 16'h00FF, 1'b0, 1'b0, 8,            1'b0);
        issue( 5, 2'd2, 1'b1, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 0,            1'b0);
        issue( 6, 2'd2, 1'b1, 16'h0003, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b1, 16,           1'b0);
        issue( 7, 2'd1, 1'b1, 16'h0000, 16'hFFFE, 16'h0003, 16'hFFFA, 16'hFFFF, 1'b0, 1'b0, mcyc(16, 2),  1'b0);
        issue( 8, 2'd1, 1'b1, 16'h0000, 16'h4000, 16'h0002, 16'h8000, 16'h0000, 1'b1, 1'b0, mcyc(16, 2),  1'b0);
        issue( 9, 2'd0, 1'b0, 16'h0000, 16'h0080, 16'h0002, 16'h0100, 16'h0000, 1'b1, 1'b0, mcyc(8, 2),   1'b0);
        issue(10, 2'd3, 1'b1, 16'hFFFF, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 16,           1'b0);
        issue(11, 2'd3, 1'b1, 16'h0000, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1, 16,           1'b0);
        issue(12, 2'd3, 1'b0, 16'h0000, 16'h0007, 16'h00FE, 16'h00FD, 16'h0001, 1'b0, 1'b0, 8,            1'b0);
        issue(13, 2'd2, 1'b0, 16'h0000, 16'h1234, 16'h0056, 16'h0036, 16'h0010, 1'b0, 1'b0, 8,            1'b0);
        issue(14, 2'd3, 1'b1, 16'hFFFF, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 16,           1'b0);
        issue(15, 2'd3, 1'b0, 16'h0000, 16'h0080, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1, 8,            1'b0);

        // Abort a word multiply five iterations into ITER.
        op = 2'd0; wide = 1'b1; a_lo = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero(16);
        reset = 1'b0;
        last_lo = '0; last_hi = '0; last_cy = 1'b0;
        @(negedge clk);

        issue(17, 2'd0, 1'b1, 16'h0000, 16'h1234, 16'h0001, 16'h1234, 16'h0000, 1'b0, 1'b0, mcyc(16, 1),  1'b0);

        repeat (4) @(negedge clk);
        chk("pending_requests", 99, sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
